// File: rtl/seg_display_monitor.sv
// seg_display_monitor: decodes a sampled seven-segment bus and tracks up/down count lock, errors and wraps
module seg_display_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [7:0]       seg_in,
  input  logic             dir,
  output logic [3:0]       value,
  output logic             valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  localparam logic [3:0] LOCK = 4'(LOCK_LEN);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, nstate;
  logic [7:0] seg_q;
  logic dir_q, dir_d, legal, dchg, err, wrap;
  logic [3:0] d, prev, nprev, step_cnt, nstep, expd;
  always_comb begin
    legal = 1'b1;
    d = 4'h0;
    case (seg_q)
      8'h3F: d = 4'h0;
      8'h06: d = 4'h1;
      8'h5B: d = 4'h2;
      8'h4F: d = 4'h3;
      8'h66: d = 4'h4;
      8'h6D: d = 4'h5;
      8'h7D: d = 4'h6;
      8'h07: d = 4'h7;
      8'h7F: d = 4'h8;
      8'h6F: d = 4'h9;
      8'h77: d = 4'hA;
      8'h7C: d = 4'hB;
      8'h39: d = 4'hC;
      8'h5E: d = 4'hD;
      8'h79: d = 4'hE;
      8'h71: d = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  assign dchg = dir_q ^ dir_d;
  assign expd = dir_q ? prev - 4'd1 : prev + 4'd1;
  always_comb begin
    nstate = state;
    nprev = prev;
    nstep = step_cnt;
    err = 1'b0;
    wrap = 1'b0;
    case (state)
      IDLE: if (legal) begin
        nprev = d;
        nstep = 4'd0;
        nstate = SYNC;
      end
      SYNC: if (!legal) nstate = IDLE;
      else if (dchg) begin
        nprev = d;
        nstep = 4'd0;
      end else if (d == expd) begin
        nprev = d;
        nstep = step_cnt + 4'd1;
        if (step_cnt + 4'd1 == LOCK) nstate = LOCKED;
      end else if (d != prev) begin
        nprev = d;
        nstep = 4'd0;
      end
      LOCKED: if (!legal) begin
        err = 1'b1;
        nstate = IDLE;
      end else if (dchg) begin
        nprev = d;
        nstep = 4'd0;
        nstate = SYNC;
      end else if (d == expd) begin
        nprev = d;
        wrap = dir_q ? (d == 4'hF) : (d == 4'h0);
      end else if (d != prev) begin
        // a jump to 0 is a counter restart, anything else is a sequence error
        nprev = d;
        nstep = 4'd0;
        nstate = SYNC;
        err = (d != 4'h0);
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= IDLE;
      seg_q <= '0;
      dir_q <= 1'b0;
      dir_d <= 1'b0;
      prev <= '0;
      step_cnt <= '0;
      value <= '0;
      valid <= 1'b0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_sticky <= 1'b0;
      err_count <= '0;
      wrap_count <= '0;
    end else begin
      seg_q <= seg_in;
      dir_q <= dir;
      dir_d <= dir_q;
      state <= nstate;
      prev <= nprev;
      step_cnt <= nstep;
      valid <= legal;
      if (legal) value <= d;
      locked <= (nstate == LOCKED);
      err_pulse <= err;
      err_sticky <= err_sticky | err;
      if (err && err_count != MAX) err_count <= err_count + ONE;
      if (wrap && wrap_count != MAX) wrap_count <= wrap_count + ONE;
    end
  end
endmodule

// File: tb/tb_seg_display_monitor.sv
// tb_seg_display_monitor: directed checks of decode, lock, error, wrap and saturation behaviour
module tb_seg_display_monitor;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  logic [7:0] seg_in = 8'h00;
  logic dir = 1'b0;
  logic [3:0] value;
  logic valid, locked, err_pulse, err_sticky;
  logic [7:0] err_count, wrap_count;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] codes [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  seg_display_monitor #(.LOCK_LEN(4), .CNT_W(8)) dut (
    .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .dir(dir), .value(value),
    .valid(valid), .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .wrap_count(wrap_count)
  );
  always #5 clk_2 = ~clk_2;
  task automatic put(input logic [7:0] c);
    seg_in = c;
    @(posedge clk_2);
    #1;
  endtask
  task automatic feed(input int x);
    put(codes[x]);
  endtask
  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic chk_all(input string tag, input int v, input int vl, input int lk,
                         input int ep, input int es, input int ec, input int wc);
    chk({tag, ".value"}, int'(value), v);
    chk({tag, ".valid"}, int'(valid), vl);
    chk({tag, ".locked"}, int'(locked), lk);
    chk({tag, ".err_pulse"}, int'(err_pulse), ep);
    chk({tag, ".err_sticky"}, int'(err_sticky), es);
    chk({tag, ".err_count"}, int'(err_count), ec);
    chk({tag, ".wrap_count"}, int'(wrap_count), wc);
  endtask
  initial begin
    repeat (3) @(posedge clk_2);
    #1;
    reset = 1'b0;
    put(8'h00);
    put(8'h00);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    // up count from 0; outputs trail the fed code by one feed
    feed(0);
    chk("first_invalid", int'(valid), 0);
    for (int i = 1; i < 16; i++) begin
      feed(i);
      chk_all($sformatf("up%0d", i - 1), i - 1, 1, (i - 1 >= 4) ? 1 : 0, 0, 0, 0, 0);
    end
    feed(0);
    chk_all("upF", 15, 1, 1, 0, 0, 0, 0);
    feed(1);
    chk_all("wrap_up", 0, 1, 1, 0, 0, 0, 1);
    for (int i = 2; i <= 5; i++) feed(i);
    feed(9);
    chk_all("at5", 5, 1, 1, 0, 0, 0, 1);
    feed(10);
    chk_all("seq_err", 9, 1, 0, 1, 1, 1, 1);
    feed(11);
    chk_all("seq_err_once", 10, 1, 0, 0, 1, 1, 1);
    feed(12);
    feed(13);
    chk_all("relock_pre", 12, 1, 0, 0, 1, 1, 1);
    feed(14);
    chk_all("relock", 13, 1, 1, 0, 1, 1, 1);
    put(8'h80);
    chk_all("before_ill", 14, 1, 1, 0, 1, 1, 1);
    feed(3);
    chk_all("illegal", 14, 0, 0, 1, 1, 2, 1);
    feed(4);
    chk_all("after_ill", 3, 1, 0, 0, 1, 2, 1);
    for (int i = 5; i <= 7; i++) feed(i);
    feed(0);
    chk_all("at7", 7, 1, 1, 0, 1, 2, 1);
    feed(0);
    chk_all("restart", 0, 1, 0, 0, 1, 2, 1);
    repeat (3) feed(0);
    feed(1);
    chk_all("hold0", 0, 1, 0, 0, 1, 2, 1);
    for (int i = 2; i <= 4; i++) feed(i);
    chk("restart_sync", int'(locked), 0);
    feed(5);
    chk_all("restart_relock", 4, 1, 1, 0, 1, 2, 1);
    // switch to down count; the direction change resyncs without error
    dir = 1'b1;
    feed(15);
    chk_all("down_pre", 5, 1, 1, 0, 1, 2, 1);
    feed(14);
    chk_all("dir_resync", 15, 1, 0, 0, 1, 2, 1);
    for (int i = 13; i >= 11; i--) feed(i);
    feed(10);
    chk_all("down_lock", 11, 1, 1, 0, 1, 2, 1);
    for (int i = 9; i >= 0; i--) feed(i);
    feed(15);
    chk_all("down0", 0, 1, 1, 0, 1, 2, 1);
    feed(14);
    chk_all("wrap_down", 15, 1, 1, 0, 1, 2, 2);
    dir = 1'b0;
    feed(13);
    chk_all("toggle_pre", 14, 1, 1, 0, 1, 2, 2);
    feed(14);
    chk_all("toggle", 13, 1, 0, 0, 1, 2, 2);
    for (int n = 0; n < 300; n++) begin
      for (int i = 1; i <= 5; i++) feed(i);
      put(8'h80);
    end
    feed(1);
    chk_all("saturate", 5, 0, 0, 1, 1, 255, 2);
    for (int i = 2; i <= 6; i++) feed(i);
    chk("pre_reset_lock", int'(locked), 1);
    reset = 1'b1;
    @(posedge clk_2);
    #1;
    chk_all("reset_mid", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
